// File: rtl/riscv_pkg.sv
// Shared types for the RV32I core front end.
// Fetch-queue entry layout and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between fetch and decode.
// Flush dominates push and pop; pointers wrap modulo DEPTH.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full queue may still accept a push when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, fault check, redirect
// handling and a small queue toward decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_SIZE   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        out_fault
);

    localparam int          CW         = $clog2(QUEUE_DEPTH + 1);
    localparam logic [29:0] IMEM_WORDS = 30'(IMEM_SIZE);

    logic [31:0]   pc_q, pc_d;
    fetch_state_t  state_q, state_d;
    fetch_entry_t  push_entry, head;
    logic          push, pop, flush;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;
    logic          in_range;

    assign imem_addr = pc_q;
    assign pop       = out_valid & out_ready;
    assign in_range  = (pc_q[1:0] == 2'b00) && (pc_q[31:2] < IMEM_WORDS);

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        push       = 1'b0;
        flush      = 1'b0;
        push_entry = '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else if (state_q == FETCH && (!q_full || pop)) begin
            push = 1'b1;
            if (in_range) begin
                push_entry = '{pc: pc_q, instr: imem_rd, fault: 1'b0};
                pc_d       = pc_q + 32'd4;
            end else begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Head fields are forced to zero while empty so decode never sees stale data.
    assign out_valid    = ~q_empty;
    assign out_instr    = q_empty ? 32'd0 : head.instr;
    assign out_pc       = q_empty ? 32'd0 : head.pc;
    assign out_pc_plus4 = q_empty ? 32'd0 : head.pc + 32'd4;
    assign out_fault    = q_empty ? 1'b0  : head.fault;

endmodule
